// File: rtl/seg_scan_pkg.sv
// Shared types, default sizing and helpers for the 7-segment scan controller.
// State encoding is kept as plain localparam constants for compatibility with older code.
package seg_scan_pkg;

  typedef logic [0:0] state_t;

  localparam state_t BLANK = 1'b0;
  localparam state_t SHOW  = 1'b1;

  localparam int N_DIG_DEF     = 4;
  localparam int DWELL_DEF     = 1000;
  localparam int BLANK_CYC_DEF = 16;

  // Widest digit vector nib() accepts (16 digits).
  localparam int NIB_VEC_W = 64;

  function automatic logic [3:0] nib(input logic [NIB_VEC_W-1:0] vec, input int k);
    nib = vec[4*k +: 4];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_timer.sv
// Cycle counter shared by the BLANK and SHOW states: restarts from zero on start,
// done is high during the last cycle of a state lasting load_val cycles.
module dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] load_val,
  output logic         done
);

  localparam logic [W-1:0] ONE = W'(1'b1);

  logic [W-1:0] count_r;

  assign done = (count_r == (load_val - ONE));

  // count cycles already spent in the current state
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (start) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + ONE;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N_DIG-digit 7-segment display with a
// double-buffered value, inter-digit blanking and leading-zero suppression.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int N_DIG     = N_DIG_DEF,
  parameter int DWELL     = DWELL_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*N_DIG-1:0] val_in,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic               load,
  input  logic               lz_en,
  output logic               pend,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic               dp,
  output logic [N_DIG-1:0]   dig_en,
  output logic               frame_tick
);

  localparam int MAX_CYC = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int IW      = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int VW      = 4 * N_DIG;

  localparam logic [TW-1:0]    DWELL_LEN = TW'(DWELL);
  localparam logic [TW-1:0]    BLANK_LEN = TW'(BLANK_CYC);
  localparam logic [IW-1:0]    IDX_ONE   = IW'(1'b1);
  localparam logic [IW-1:0]    IDX_LAST  = IW'(N_DIG - 1);
  localparam logic [N_DIG-1:0] DIG_ONE   = N_DIG'(1'b1);

  // State registers describe the cycle about to be output on the next edge.
  state_t            state_r;
  logic [IW-1:0]     idx_r;
  logic              wrap_r;

  logic [VW-1:0]     shadow_val_r;
  logic [N_DIG-1:0]  shadow_dp_r;
  logic              shadow_lz_r;
  logic [VW-1:0]     active_val_r;
  logic [N_DIG-1:0]  active_dp_r;
  logic              active_lz_r;

  logic [TW-1:0]     dur_s;
  logic              done_s;
  logic              last_dig_s;
  logic [3:0]        nib_s;
  logic [N_DIG-1:0]  supp_s;
  logic              zero_run_s;

  assign dur_s      = (state_r == SHOW) ? DWELL_LEN : BLANK_LEN;
  assign last_dig_s = (idx_r == IDX_LAST);
  assign nib_s      = nib(NIB_VEC_W'(active_val_r), int'(idx_r));

  dwell_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (done_s),
    .load_val (dur_s),
    .done     (done_s)
  );

  // digit k is dark when it and every digit above it carry neither a value nor a dp
  always_comb begin
    zero_run_s = 1'b1;
    supp_s     = '0;
    for (int k = N_DIG - 1; k > 0; k--) begin
      zero_run_s = zero_run_s & (nib(NIB_VEC_W'(active_val_r), k) == 4'd0) & ~active_dp_r[k];
      supp_s[k]  = zero_run_s & active_lz_r;
    end
  end

  // BLANK/SHOW sequencing and digit index; flags the start of each new frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= BLANK;
      idx_r   <= '0;
      wrap_r  <= 1'b0;
    end else if (done_s) begin
      if (state_r == SHOW) begin
        state_r <= BLANK;
        idx_r   <= last_dig_s ? '0 : (idx_r + IDX_ONE);
        wrap_r  <= last_dig_s;
      end else begin
        state_r <= SHOW;
        wrap_r  <= 1'b0;
      end
    end else begin
      wrap_r <= 1'b0;
    end
  end

  // registered display outputs for the cycle selected by the state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_en       <= '0;
      {a, b, c, d} <= 4'b0000;
      dp           <= 1'b0;
      frame_tick   <= 1'b0;
    end else begin
      frame_tick <= wrap_r;
      if (state_r == SHOW) begin
        dig_en       <= (DIG_ONE << idx_r) & ~supp_s;
        {a, b, c, d} <= nib_s;
        dp           <= active_dp_r[idx_r];
      end else begin
        dig_en       <= '0;
        {a, b, c, d} <= 4'b0000;
        dp           <= 1'b0;
      end
    end
  end

  // Shadow/active double buffer: the swap happens only at the end of the wrap
  // cycle, so a load in that same cycle stays pending for the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_val_r <= '0;
      shadow_dp_r  <= '0;
      shadow_lz_r  <= 1'b0;
      active_val_r <= '0;
      active_dp_r  <= '0;
      active_lz_r  <= 1'b0;
      pend         <= 1'b0;
    end else begin
      if (load) begin
        shadow_val_r <= val_in;
        shadow_dp_r  <= dp_in;
        shadow_lz_r  <= lz_en;
      end else begin
        shadow_val_r <= shadow_val_r;
        shadow_dp_r  <= shadow_dp_r;
        shadow_lz_r  <= shadow_lz_r;
      end
      if (frame_tick && pend) begin
        active_val_r <= shadow_val_r;
        active_dp_r  <= shadow_dp_r;
        active_lz_r  <= shadow_lz_r;
      end else begin
        active_val_r <= active_val_r;
        active_dp_r  <= active_dp_r;
        active_lz_r  <= active_lz_r;
      end
      pend <= load | (pend & ~frame_tick);
    end
  end

endmodule
